// File: rtl/ras_controller.sv
// ras_controller
//   Sequencing controller for the return-address-stack (RAS) storage array.
//   Classifies resolved jal/jalr requests by their x1/x5 link hints, drives
//   the array read/write strobes, keeps the top-of-stack pointer and
//   occupancy count, returns predicted return addresses, and holds
//   per-branch {tos, count} checkpoints for misprediction recovery.
//
// Ports
//   clk_in, rst_n_in             clock, synchronous active-low reset
//   req_valid_in / req_ready_out jump request handshake
//   jal_in, rd_in, rs1_in        instruction class and register hints
//   link_addr_in                 pc+4 to push
//   ckpt_save_in, ckpt_tag_in    snapshot {tos, count} into a slot
//   recover_in, recover_tag_in   restore {tos, count} from a slot
//   ras_wr_*_out                 array write port
//   ras_rd_en_out/addr_out       array read request (data one cycle later)
//   ras_rd_data_in               array read data
//   pred_valid/hit/addr_out      pop result pulse
//   count_out                    current occupancy
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request
// ISSUE  | drive array strobes, update tos/count
// WAIT   | array read in flight, capture read data
// RESP   | present prediction (hit or underflow miss)
module ras_controller #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int XLEN  = 64,
    parameter int NCKPT = 4,
    parameter int TAG_W = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               req_valid_in,
    output logic               req_ready_out,
    input  logic               jal_in,
    input  logic [4:0]         rd_in,
    input  logic [4:0]         rs1_in,
    input  logic [XLEN-1:0]    link_addr_in,
    input  logic               ckpt_save_in,
    input  logic [TAG_W-1:0]   ckpt_tag_in,
    input  logic               recover_in,
    input  logic [TAG_W-1:0]   recover_tag_in,
    output logic               ras_wr_en_out,
    output logic [PTR_W-1:0]   ras_wr_addr_out,
    output logic [XLEN-1:0]    ras_wr_data_out,
    output logic               ras_rd_en_out,
    output logic [PTR_W-1:0]   ras_rd_addr_out,
    input  logic [XLEN-1:0]    ras_rd_data_in,
    output logic               pred_valid_out,
    output logic               pred_hit_out,
    output logic [XLEN-1:0]    pred_addr_out,
    output logic [PTR_W:0]     count_out
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] TOS_RST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_POPPUSH} op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d, req_op;
    logic [XLEN-1:0]   link_q, link_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              hit_q, hit_d;
    logic [PTR_W-1:0]  tos_q, tos_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  ckpt_tos_q [NCKPT];
    logic [CNT_W-1:0]  ckpt_cnt_q [NCKPT];

    logic              rd_link, rs1_link, accept;
    logic              wr_en, rd_en, pv, ph;
    logic [PTR_W-1:0]  wr_addr, rd_addr;
    logic [XLEN-1:0]   wr_data, pa;

    assign rd_link  = (rd_in == 5'd1) || (rd_in == 5'd5);
    assign rs1_link = (rs1_in == 5'd1) || (rs1_in == 5'd5);

    always_comb begin
        req_op = OP_NONE;
        if (jal_in) begin
            if (rd_link) req_op = OP_PUSH;
        end else if (!rd_link && rs1_link) begin
            req_op = OP_POP;
        end else if (rd_link && !rs1_link) begin
            req_op = OP_PUSH;
        end else if (rd_link && rs1_link) begin
            req_op = (rd_in != rs1_in) ? OP_POPPUSH : OP_PUSH;
        end
    end

    assign req_ready_out = rst_n_in && (state_q == S_IDLE) && !recover_in;
    assign accept        = req_valid_in && req_ready_out;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        link_d  = link_q;
        data_d  = data_q;
        hit_d   = hit_q;
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        pv      = 1'b0;
        ph      = 1'b0;
        pa      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    link_d = link_addr_in;
                    unique case (req_op)
                        OP_PUSH: begin
                            op_d    = OP_PUSH;
                            state_d = S_ISSUE;
                        end
                        OP_POP: begin
                            if (count_q != '0) begin
                                op_d    = OP_POP;
                                state_d = S_ISSUE;
                            end else begin
                                // Underflow: report a miss straight away.
                                op_d    = OP_NONE;
                                hit_d   = 1'b0;
                                data_d  = '0;
                                state_d = S_RESP;
                            end
                        end
                        OP_POPPUSH: begin
                            // Nothing to pop on an empty stack: plain push.
                            op_d    = (count_q != '0) ? OP_POPPUSH : OP_PUSH;
                            state_d = S_ISSUE;
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                unique case (op_q)
                    OP_PUSH: begin
                        wr_en   = 1'b1;
                        wr_addr = tos_q + PTR_W'(1);
                        wr_data = link_q;
                        tos_d   = tos_q + PTR_W'(1);
                        count_d = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);
                        state_d = S_IDLE;
                    end
                    OP_POP: begin
                        rd_en   = 1'b1;
                        rd_addr = tos_q;
                        tos_d   = tos_q - PTR_W'(1);
                        count_d = count_q - CNT_W'(1);
                        state_d = S_WAIT;
                    end
                    OP_POPPUSH: begin
                        // Read-before-write array: the read returns the old entry.
                        rd_en   = 1'b1;
                        rd_addr = tos_q;
                        wr_en   = 1'b1;
                        wr_addr = tos_q;
                        wr_data = link_q;
                        state_d = S_WAIT;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_WAIT: begin
                data_d  = ras_rd_data_in;
                hit_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                pv      = 1'b1;
                ph      = hit_q;
                pa      = data_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Recovery overrides everything and kills whatever was in flight.
        if (recover_in) begin
            state_d = S_IDLE;
            op_d    = OP_NONE;
            tos_d   = ckpt_tos_q[recover_tag_in];
            count_d = ckpt_cnt_q[recover_tag_in];
            wr_en   = 1'b0;
            wr_addr = '0;
            wr_data = '0;
            rd_en   = 1'b0;
            rd_addr = '0;
            pv      = 1'b0;
            ph      = 1'b0;
            pa      = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            link_q  <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
            tos_q   <= TOS_RST;
            count_q <= '0;
            for (int i = 0; i < NCKPT; i++) begin
                ckpt_tos_q[i] <= TOS_RST;
                ckpt_cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            link_q  <= link_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
            tos_q   <= tos_d;
            count_q <= count_d;
            // Snapshot the pre-update values; a restore of the same slot wins.
            if (ckpt_save_in && !(recover_in && (ckpt_tag_in == recover_tag_in))) begin
                ckpt_tos_q[ckpt_tag_in] <= tos_q;
                ckpt_cnt_q[ckpt_tag_in] <= count_q;
            end
        end
    end

    // Outputs are forced low while reset is held.
    assign ras_wr_en_out   = rst_n_in && wr_en;
    assign ras_wr_addr_out = rst_n_in ? wr_addr : '0;
    assign ras_wr_data_out = rst_n_in ? wr_data : '0;
    assign ras_rd_en_out   = rst_n_in && rd_en;
    assign ras_rd_addr_out = rst_n_in ? rd_addr : '0;
    assign pred_valid_out  = rst_n_in && pv;
    assign pred_hit_out    = rst_n_in && ph;
    assign pred_addr_out   = rst_n_in ? pa : '0;
    assign count_out       = rst_n_in ? count_q : '0;

endmodule
